// File: rtl/xrv_slot_alloc.sv
// Slot/tag allocator: offers the lowest-index free slot, accepts releases by index,
// and keeps a registered busy mask, free count and illegal-release pulse.
module xrv_slot_alloc #(
  parameter  int NUM_SLOTS_P = 16,
  localparam int IDX_W       = $clog2(NUM_SLOTS_P),
  localparam int CNT_W       = $clog2(NUM_SLOTS_P + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  output logic                   alloc_valid_o,
  input  logic                   alloc_ready_i,
  output logic [IDX_W-1:0]       alloc_idx_o,
  input  logic                   rel_valid_i,
  input  logic [IDX_W-1:0]       rel_idx_i,
  output logic                   rel_ready_o,
  output logic [NUM_SLOTS_P-1:0] busy_mask_o,
  output logic [CNT_W-1:0]       free_cnt_o,
  output logic                   empty_o,
  output logic                   err_rel_o
);

  logic [NUM_SLOTS_P-1:0] busy_q, busy_d;
  logic [CNT_W-1:0]       free_cnt_q, free_cnt_d;
  logic                   err_q, err_d;

  logic [IDX_W-1:0]       lowest_free;
  logic                   any_free;
  logic                   alloc_fire;
  logic [NUM_SLOTS_P-1:0] alloc_set;
  logic [NUM_SLOTS_P-1:0] rel_onehot;
  logic                   rel_legal;

  // Scan from the top so the last hit is the lowest free index.
  always_comb begin
    lowest_free = '0;
    any_free    = 1'b0;
    for (int i = NUM_SLOTS_P - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        lowest_free = IDX_W'(i);
        any_free    = 1'b1;
      end
    end
  end

  assign alloc_valid_o = any_free & ~flush_i & rst_ni;
  assign alloc_idx_o   = lowest_free;
  assign alloc_fire    = alloc_valid_o & alloc_ready_i;
  assign alloc_set     = NUM_SLOTS_P'(alloc_fire) << lowest_free;

  // An out-of-range index shifts the bit off the top, so it decodes to no slot.
  assign rel_onehot = NUM_SLOTS_P'(1) << rel_idx_i;
  assign rel_legal  = rel_valid_i & (|(rel_onehot & busy_q));

  always_comb begin
    busy_d     = busy_q;
    free_cnt_d = free_cnt_q;
    err_d      = 1'b0;
    if (flush_i) begin
      busy_d     = '0;
      free_cnt_d = CNT_W'(NUM_SLOTS_P);
    end else begin
      busy_d     = (busy_q | alloc_set) & ~(rel_legal ? rel_onehot : '0);
      free_cnt_d = free_cnt_q - CNT_W'(alloc_fire) + CNT_W'(rel_legal);
      err_d      = rel_valid_i & ~rel_legal;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      busy_q     <= '0;
      free_cnt_q <= CNT_W'(NUM_SLOTS_P);
      err_q      <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      free_cnt_q <= free_cnt_d;
      err_q      <= err_d;
    end
  end

  assign rel_ready_o = rst_ni;
  assign busy_mask_o = busy_q;
  assign free_cnt_o  = free_cnt_q;
  assign empty_o     = (free_cnt_q == CNT_W'(NUM_SLOTS_P));
  assign err_rel_o   = err_q;

  a_cnt_matches_mask: assert property (@(posedge clk_i) disable iff (!rst_ni)
    free_cnt_q == CNT_W'($countones(~busy_q)));

endmodule

// File: doc/xrv_slot_alloc.md
Name: xrv_slot_alloc

Overview:
Slot/tag allocator for small tracking structures (LSU outstanding-request tags, scoreboard entries).
- Allocate direction: priority-encodes the free-slot mask to grant the lowest-index free slot.
- Release direction: decodes a returned slot index to a one-hot mask and clears the slot's busy bit.
- Keeps a registered busy mask and free count, and flags illegal releases.

Parameters:
NUM_SLOTS_P, 16, number of slots; any value >= 2, power of two not required. Derived localparams: IDX_W = $clog2(NUM_SLOTS_P), CNT_W = $clog2(NUM_SLOTS_P+1).

Ports:
clk_i  input  1  clock; all state updates on rising edge
rst_ni  input  1  reset, synchronous and active-low
flush_i  input  1  release every slot at the next edge
alloc_valid_o  output  1  a free slot is offered
alloc_ready_i  input  1  consumer takes the offered slot
alloc_idx_o  output  IDX_W  index of offered slot (lowest free)
rel_valid_i  input  1  release request
rel_idx_i  input  IDX_W  index being released
rel_ready_o  output  1  release accepted; tied 1 except during reset
busy_mask_o  output  NUM_SLOTS_P  registered busy bit per slot
free_cnt_o  output  CNT_W  registered count of free slots
empty_o  output  1  no slot busy (free_cnt_o == NUM_SLOTS_P)
err_rel_o  output  1  one-cycle pulse: illegal release detected

Behaviour:
- Reset (rst_ni low at an edge): busy_q = 0, free_cnt_q = NUM_SLOTS_P, err_q = 0. While rst_ni is low, alloc_valid_o and rel_ready_o are forced 0. After reset: alloc_valid_o = 1, alloc_idx_o = 0, empty_o = 1.
- Offer:
  - alloc_valid_o = (|~busy_q) & ~flush_i & rst_ni.
  - alloc_idx_o = index of the lowest set bit of ~busy_q, and 0 when none is set.
  - Both depend only on registered state, flush_i and rst_ni; there is no combinational path from alloc_ready_i or the rel_* inputs.
- Alloc fire = alloc_valid_o & alloc_ready_i. The busy bit of alloc_idx_o is set at the next edge, and that slot disappears from the offer one cycle after the fire. Consecutive fires grant 0, 1, 2, ... while those slots are free.
- Release legality:
  - Legal when rel_valid_i, rel_idx_i < NUM_SLOTS_P, and busy_q[rel_idx_i] = 1. The decoded one-hot bit is cleared at the next edge.
  - Otherwise (index out of range, or slot already free) it is illegal: no state change, err_rel_o = 1 for exactly the following cycle.
- No bypass: a slot released in cycle N is first offerable in cycle N+1, because alloc_idx_o is computed from busy_q.
- Simultaneous alloc fire and legal release of different slots: both apply. free_cnt_q is unchanged net.
- Release of the slot being offered in the same cycle: that slot is free, so the release is illegal (err pulse). The alloc fire proceeds normally.
- free_cnt_q update: -1 on alloc fire only, +1 on legal release only, 0 on both or neither. It never underflows or overflows. It equals popcount(~busy_q) at all times; this is an assertion target.
- Flush:
  - busy_q = 0 and free_cnt_q = NUM_SLOTS_P at the next edge, overriding alloc and release in the same cycle.
  - alloc_valid_o is 0 during flush, so no grant is lost.
  - A release in the flush cycle raises no error.
- Full: busy_q all ones gives alloc_valid_o = 0 and alloc_idx_o = 0; alloc_ready_i is ignored.
- Reset mid-operation: all state returns to reset values at the edge and any in-flight alloc or release is dropped. Priority order: reset > flush > alloc/release.
- Error pulse: err_rel_o is registered and never held longer than one cycle per illegal request. Back-to-back illegal releases give a continuous high.

Test Plan:
- Reset, NUM_SLOTS_P=16: hold rst_ni=0 for 2 cycles then release -> during reset alloc_valid_o=0; after reset alloc_valid_o=1, alloc_idx_o=0, free_cnt_o=16, empty_o=1, busy_mask_o=0.
- Fill: alloc_ready_i=1 for 16 cycles -> grants 0..15 in order; then alloc_valid_o=0, busy_mask_o=16'hFFFF, free_cnt_o=0; a 17th ready is ignored.
- Release/reuse: from full, release idx 5 then idx 2 on consecutive cycles -> free_cnt_o goes 1 then 2; cycle after the idx-2 release alloc_idx_o=2; idx 5 is not offered in the same cycle as its release.
- Simultaneous: busy 0..3, alloc fire (offers 4) plus release idx 1 in the same cycle -> next cycle busy_mask_o=16'h001D, free_cnt_o=12, alloc_idx_o=1.
- Illegal release: release idx 7 while free -> err_rel_o=1 for exactly one cycle, busy_mask_o unchanged. With NUM_SLOTS_P=12, release idx 13 -> err pulse, no state change.
- Flush: busy 0..9, flush_i=1 together with alloc_ready_i=1 and a legal release of idx 3 -> alloc_valid_o=0 that cycle; next cycle busy_mask_o=0, free_cnt_o=16, err_rel_o=0, alloc_idx_o=0.
